// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: stall merge, multi-cycle EX timer, trap/branch redirect
module pipe_ctrl #(
  parameter int          MC_CYCLES = 8,
  parameter logic [11:0] TRAP_VEC  = 12'h010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_mem,
  input  logic        mc_start,
  input  logic        branch_req,
  input  logic [11:0] branch_target,
  input  logic        trap_req,
  output logic [5:0]  stall,
  output logic [5:0]  flush,
  output logic        branch,
  output logic [11:0] branch_pc,
  output logic        mc_done
);

  localparam int CW = $clog2(MC_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_flush;
  logic          r_branch;
  logic [11:0]   r_branch_pc;

  logic w_mc_start;
  logic w_mc_stall;
  logic w_trap_acc;
  logic w_br_acc;

  // The start cycle already holds EX, so the counter covers the remaining cycles.
  assign w_mc_start = (r_state == S_IDLE) && mc_start && !trap_req;
  assign w_mc_stall = w_mc_start || ((r_state == S_BUSY) && (r_cnt != '0));

  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (w_mc_stall)  stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

  assign mc_done    = !rst && (r_state == S_BUSY) && (r_cnt == '0);
  assign w_trap_acc = !rst && trap_req && !stall[4];
  assign w_br_acc   = !rst && branch_req && !stall[3] && !w_trap_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mc_start) begin
            r_state <= S_BUSY;
            r_cnt   <= CW'(MC_CYCLES - 2);
          end
        end
        S_BUSY: begin
          if (w_trap_acc) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt != '0) begin
            if (!stallreq_mem) r_cnt <= r_cnt - CW'(1);
          end else if (!stallreq_mem) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Redirect strobe lasts one cycle; the target register keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch    <= 1'b0;
      r_branch_pc <= 12'h000;
      r_flush     <= 6'b000000;
    end else if (w_trap_acc) begin
      r_branch    <= 1'b1;
      r_branch_pc <= TRAP_VEC;
      r_flush     <= 6'b001110;
    end else if (w_br_acc) begin
      r_branch    <= 1'b1;
      r_branch_pc <= branch_target;
      r_flush     <= 6'b000110;
    end else begin
      r_branch    <= 1'b0;
      r_flush     <= 6'b000000;
    end
  end

  assign branch    = r_branch;
  assign branch_pc = r_branch_pc;
  assign flush     = r_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_mem, mc_start, branch_req, trap_req;
  logic [11:0] branch_target;
  logic [5:0]  stall, flush;
  logic        branch, mc_done;
  logic [11:0] branch_pc;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MC_CYCLES(8), .TRAP_VEC(12'h010)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .mc_start(mc_start), .branch_req(branch_req),
    .branch_target(branch_target), .trap_req(trap_req),
    .stall(stall), .flush(flush), .branch(branch),
    .branch_pc(branch_pc), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id, mem, br;
    logic [11:0] tgt;
    logic        trap;
    logic [5:0]  exp_stall;
    logic        exp_br;
    logic [11:0] exp_pc;
    logic [5:0]  exp_flush;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    stallreq_id = 0; stallreq_mem = 0; mc_start = 0;
    branch_req = 0; trap_req = 0; branch_target = 12'h000;
  endtask

  task automatic run_mc(input int mem_at, input int mem_len, input int done_at, input string tag);
    logic [5:0] es;
    for (int k = 0; k <= done_at + 2; k++) begin
      @(negedge clk);
      mc_start     = (k == 0);
      stallreq_mem = (k >= mem_at) && (k < mem_at + mem_len);
      #1;
      if (stallreq_mem)     es = 6'b011111;
      else if (k < done_at) es = 6'b001111;
      else                  es = 6'b000000;
      chk($sformatf("%s stall c%0d", tag, k), 32'(stall), 32'(es));
      chk($sformatf("%s mc_done c%0d", tag, k), 32'(mc_done), 32'(k == done_at));
    end
    clr();
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 12'h000, 0, 6'b000000, 0, 12'h000, 6'b000000};
    vecs[1]  = '{1, 0, 0, 12'h000, 0, 6'b000111, 0, 12'h000, 6'b000000};
    vecs[2]  = '{1, 1, 0, 12'h000, 0, 6'b011111, 0, 12'h000, 6'b000000};
    vecs[3]  = '{0, 0, 1, 12'h0A4, 0, 6'b000000, 1, 12'h0A4, 6'b000110};
    vecs[4]  = '{0, 1, 1, 12'h0B0, 0, 6'b011111, 0, 12'h0A4, 6'b000000};
    vecs[5]  = '{1, 0, 1, 12'h0B0, 0, 6'b000111, 1, 12'h0B0, 6'b000110};
    vecs[6]  = '{0, 0, 1, 12'h0C0, 1, 6'b000000, 1, 12'h010, 6'b001110};
    vecs[7]  = '{0, 1, 0, 12'h000, 1, 6'b011111, 0, 12'h010, 6'b000000};
    vecs[8]  = '{0, 0, 1, 12'h0D0, 0, 6'b000000, 1, 12'h0D0, 6'b000110};
    vecs[9]  = '{0, 0, 1, 12'h0E0, 0, 6'b000000, 1, 12'h0E0, 6'b000110};
    vecs[10] = '{0, 0, 0, 12'h000, 1, 6'b000000, 1, 12'h010, 6'b001110};
    vecs[11] = '{0, 0, 0, 12'h000, 0, 6'b000000, 0, 12'h010, 6'b000000};

    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);

    // reset dominates random activity on every input
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stallreq_id = 1'($urandom); stallreq_mem = 1'($urandom);
      mc_start = 1'($urandom); branch_req = 1'($urandom);
      trap_req = 1'($urandom); branch_target = 12'($urandom);
      #1;
      chk($sformatf("rst stall c%0d", c), 32'(stall), 32'h0);
      chk($sformatf("rst flush c%0d", c), 32'(flush), 32'h0);
      chk($sformatf("rst branch c%0d", c), 32'(branch), 32'h0);
      chk($sformatf("rst mc_done c%0d", c), 32'(mc_done), 32'h0);
      chk($sformatf("rst branch_pc c%0d", c), 32'(branch_pc), 32'h0);
    end
    @(negedge clk);
    clr();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      stallreq_id = vecs[i].id; stallreq_mem = vecs[i].mem;
      branch_req = vecs[i].br; branch_target = vecs[i].tgt;
      trap_req = vecs[i].trap; mc_start = 1'b0;
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d mc_done", i), 32'(mc_done), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d branch", i), 32'(branch), 32'(vecs[i].exp_br));
      chk($sformatf("vec%0d branch_pc", i), 32'(branch_pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].exp_flush));
    end
    @(negedge clk);
    clr();

    run_mc(0, 0, 7, "mc");
    run_mc(3, 2, 9, "mc_mem");

    // trap while busy aborts the op; a branch held by the EX stall is not taken
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      mc_start   = (k == 0);
      branch_req = (k == 1);
      branch_target = 12'h0F0;
      trap_req   = (k == 2);
      #1;
      chk($sformatf("trapbusy stall c%0d", k), 32'(stall), (k <= 2) ? 32'h0F : 32'h0);
      chk($sformatf("trapbusy mc_done c%0d", k), 32'(mc_done), 32'h0);
      if (k == 2) chk("trapbusy held branch", 32'(branch), 32'h0);
      if (k == 3) begin
        chk("trapbusy branch", 32'(branch), 32'h1);
        chk("trapbusy branch_pc", 32'(branch_pc), 32'h010);
        chk("trapbusy flush", 32'(flush), 32'h0E);
      end
    end
    clr();

    // trap and mc_start together: no op is started
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      mc_start = (k == 0);
      trap_req = (k == 0);
      #1;
      chk($sformatf("trapstart stall c%0d", k), 32'(stall), 32'h0);
      chk($sformatf("trapstart mc_done c%0d", k), 32'(mc_done), 32'h0);
      if (k == 1) chk("trapstart branch", 32'(branch), 32'h1);
    end
    clr();

    // reset in the middle of an op, then a full op afterwards
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      mc_start = (k == 0);
      rst      = (k == 3);
      #1;
      chk($sformatf("midrst stall c%0d", k), 32'(stall), (k <= 2) ? 32'h0F : 32'h0);
      chk($sformatf("midrst mc_done c%0d", k), 32'(mc_done), 32'h0);
    end
    clr();
    run_mc(0, 0, 7, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
